// File: rtl/data_mem_responder.sv
// Data-memory responder: decoded word window, single-cycle writes,
// fixed-latency read pipeline, sticky error flag, access counter.
// Params: ADDR_WIDTH, BASE_ADDR, RD_LATENCY (1..3), ERR_DATA.
// Ports: CLK, reset (sync, active-high), CS, WE, ADDR, Data_BUS_WRITE
//   in; Data_BUS_READ, rd_valid, addr_err, access_cnt, busy out.
// Macro DMEM_SCRUB_EN: zero the array after reset, busy while scrubbing.
module data_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_2000,
  parameter int unsigned RD_LATENCY = 1,
  parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        CS,
  input  logic        WE,
  input  logic [31:0] ADDR,
  input  logic [31:0] Data_BUS_WRITE,
  output logic [31:0] Data_BUS_READ,
  output logic        rd_valid,
  output logic        addr_err,
  output logic [15:0] access_cnt,
  output logic        busy
);

  localparam int unsigned DEPTH = 2**ADDR_WIDTH;
  localparam logic [32:0] LAST =
    {1'b0, BASE_ADDR} + (33'(DEPTH) << 2) - 33'd4;

  logic [31:0] mem [DEPTH];

  logic                  hit;
  logic [31:0]           offs;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  accept;
  logic                  wr_hit;
  logic                  rd_iss;
  logic [31:0]           rd_word;
  logic                  busy_w;

  assign offs = ADDR - BASE_ADDR;
  assign idx  = ADDR_WIDTH'(offs >> 2);
  assign hit  = (ADDR[1:0] == 2'b00)
             && (ADDR >= BASE_ADDR)
             && ({1'b0, ADDR} <= LAST);

  assign accept  = CS && !busy_w;
  assign wr_hit  = accept && WE && hit;
  assign rd_iss  = accept && !WE;
  // Combinational array read: sampled at the issue edge, so a write
  // on that same edge is not yet visible.
  assign rd_word = hit ? mem[idx] : ERR_DATA;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_wa;
  logic [31:0]           mem_wd;

`ifdef DMEM_SCRUB_EN
  typedef enum logic {
    S_IDLE,
    S_SCRUB
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= S_SCRUB;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      S_SCRUB: begin
        ptr_d = ptr_q + ADDR_WIDTH'(1);
        if (&ptr_q) state_d = S_IDLE;
      end
      default: ;
    endcase
  end

  always_comb begin
    busy_w = (state_q == S_SCRUB);
    mem_we = busy_w ? 1'b1 : wr_hit;
    mem_wa = busy_w ? ptr_q : idx;
    mem_wd = busy_w ? 32'h0 : Data_BUS_WRITE;
  end
`else
  assign busy_w = 1'b0;
  assign mem_we = wr_hit;
  assign mem_wa = idx;
  assign mem_wd = Data_BUS_WRITE;
`endif

  assign busy = busy_w;

  always_ff @(posedge CLK) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  // Read pipeline; the last stage is the output register and holds
  // its data between pulses.
  logic [RD_LATENCY-1:0] pv_q, pv_d;
  logic [31:0]           pd_q [RD_LATENCY];
  logic [31:0]           pd_d [RD_LATENCY];
  logic [RD_LATENCY-1:0] in_v;
  logic [31:0]           in_d [RD_LATENCY];

  always_comb begin
    in_v[0] = rd_iss;
    in_d[0] = rd_word;
    for (int i = 1; i < RD_LATENCY; i++) begin
      in_v[i] = pv_q[i-1];
      in_d[i] = pd_q[i-1];
    end
    pv_d = in_v;
    for (int i = 0; i < RD_LATENCY; i++) begin
      pd_d[i] = in_v[i] ? in_d[i] : pd_q[i];
    end
  end

  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    err_d = err_q | (accept & ~hit);
    cnt_d = cnt_q;
    if (accept && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      pv_q  <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) pd_q[i] <= '0;
    end else begin
      pv_q  <= pv_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < RD_LATENCY; i++) pd_q[i] <= pd_d[i];
    end
  end

  assign Data_BUS_READ = pd_q[RD_LATENCY-1];
  assign rd_valid      = pv_q[RD_LATENCY-1];
  assign addr_err      = err_q;
  assign access_cnt    = cnt_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances at read latency 1..3
// share one stimulus stream; a per-instance scoreboard checks reads.
module tb_data_mem_responder;

`ifdef DMEM_SCRUB_EN
  localparam int AW = 4;
`else
  localparam int AW = 10;
`endif
  localparam int DEPTH = 2**AW;
  localparam logic [31:0] BASE = 32'h0000_2000;
  localparam logic [31:0] TOP  = BASE + 32'(4*DEPTH) - 32'd4;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        CS = 1'b0;
  logic        WE = 1'b0;
  logic [31:0] ADDR = '0;
  logic [31:0] Data_BUS_WRITE = '0;

  logic [31:0] rd  [3];
  logic        rdv [3];
  logic        err [3];
  logic [15:0] cnt [3];
  logic        bsy [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_mem_responder #(
      .ADDR_WIDTH(AW),
      .BASE_ADDR(BASE),
      .RD_LATENCY(g + 1),
      .ERR_DATA(ERRD)
    ) u_dut (
      .CLK(CLK),
      .reset(reset),
      .CS(CS),
      .WE(WE),
      .ADDR(ADDR),
      .Data_BUS_WRITE(Data_BUS_WRITE),
      .Data_BUS_READ(rd[g]),
      .rd_valid(rdv[g]),
      .addr_err(err[g]),
      .access_cnt(cnt[g]),
      .busy(bsy[g])
    );
  end

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] d;
    int          cyc;
  } exp_t;

  typedef struct {
    bit          cs;
    bit          we;
    logic [31:0] a;
    logic [31:0] wd;
    bit          err;
  } vec_t;

  exp_t        sbq [3][$];
  logic [31:0] mem_m [int];
  bit          err_m;
  logic [15:0] cnt_m;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  int          n_chk = 0;
  int          n_pass = 0;
  vec_t        tbl [15];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input bit ok, input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h want %h (cyc %0d)",
                  nm, act, exp, cyc);
  endtask

  function automatic bit hit_m(input logic [31:0] a);
    return (a % 4 == 0) && (a >= BASE) && (a < BASE + 4*DEPTH);
  endfunction

  always @(negedge CLK) begin : mon
    bit ev;
    exp_t e;
    if (mon_en) begin
      for (int k = 0; k < 3; k++) begin
        ev = (sbq[k].size() > 0) && (sbq[k][0].cyc == cyc);
        check(rdv[k] === ev, $sformatf("rd_valid_L%0d", k + 1),
              32'(rdv[k]), 32'(ev));
        if (ev) begin
          e = sbq[k].pop_front();
          if (rdv[k] === 1'b1)
            check(rd[k] === e.d, $sformatf("rdata_L%0d", k + 1),
                  rd[k], e.d);
        end
      end
    end
  end

  task automatic step(input bit cs, input bit we,
                      input logic [31:0] a, input logic [31:0] wd);
    bit h;
    int ix;
    CS = cs;
    WE = we;
    ADDR = a;
    Data_BUS_WRITE = wd;
    if (cs) begin
      h = hit_m(a);
      ix = int'((a - BASE) >> 2);
      if (!h) err_m = 1'b1;
      if (cnt_m != 16'hFFFF) cnt_m++;
      if (!we) begin
        for (int k = 0; k < 3; k++)
          sbq[k].push_back('{h ? mem_m[ix] : ERRD, cyc + 1 + k});
      end else if (h) begin
        mem_m[ix] = wd;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_status(input bit e_err, input logic [15:0] e_cnt);
    for (int k = 0; k < 3; k++) begin
      check(err[k] === e_err, "addr_err", 32'(err[k]), 32'(e_err));
      check(cnt[k] === e_cnt, "access_cnt", 32'(cnt[k]), 32'(e_cnt));
    end
  endtask

  task automatic do_reset(input int n);
    int lim;
    lim = cyc + 1;
    reset = 1'b1;
    CS = 1'b0;
    WE = 1'b0;
    for (int k = 0; k < 3; k++)
      while (sbq[k].size() > 0 && sbq[k][$].cyc >= lim)
        void'(sbq[k].pop_back());
    err_m = 1'b0;
    cnt_m = '0;
    repeat (n) @(posedge CLK);
    #1;
    for (int k = 0; k < 3; k++) begin
      check(rd[k] === 32'h0, "rst_rdata", rd[k], 32'h0);
      check(rdv[k] === 1'b0, "rst_rd_valid", 32'(rdv[k]), 32'h0);
    end
    chk_status(1'b0, 16'h0);
    reset = 1'b0;
`ifdef DMEM_SCRUB_EN
    for (int i = 0; i < DEPTH; i++) begin
      for (int k = 0; k < 3; k++)
        check(bsy[k] === 1'b1, "busy_hi", 32'(bsy[k]), 32'h1);
      CS = (i < 2);
      WE = (i == 0);
      ADDR = (i == 0) ? BASE : BASE + 32'd2;
      Data_BUS_WRITE = 32'hFFFF_FFFF;
      @(posedge CLK);
      #1;
    end
    CS = 1'b0;
    WE = 1'b0;
    for (int k = 0; k < 3; k++)
      check(bsy[k] === 1'b0, "busy_lo", 32'(bsy[k]), 32'h0);
    chk_status(1'b0, 16'h0);
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
`else
    for (int k = 0; k < 3; k++)
      check(bsy[k] === 1'b0, "busy_off", 32'(bsy[k]), 32'h0);
`endif
  endtask

  initial begin
    tbl[0]  = '{1, 1, TOP,          32'h5555_0001, 0};
    tbl[1]  = '{1, 0, TOP,          32'h0,         0};
    tbl[2]  = '{1, 1, BASE + 32'h10, 32'h0000_0010, 0};
    tbl[3]  = '{1, 0, BASE + 32'h10, 32'h0,         0};
    tbl[4]  = '{1, 0, BASE + 32'h10, 32'h0,         0};
    tbl[5]  = '{1, 1, BASE + 32'h10, 32'h0000_0020, 0};
    tbl[6]  = '{1, 0, BASE + 32'h10, 32'h0,         0};
    tbl[7]  = '{0, 1, BASE + 32'h10, 32'hFFFF_FFFF, 0};
    tbl[8]  = '{1, 0, BASE + 32'h10, 32'h0,         0};
    tbl[9]  = '{0, 0, 32'h0,        32'h0,         0};
    tbl[10] = '{1, 0, BASE + 32'h2, 32'h0,         1};
    tbl[11] = '{1, 1, TOP + 32'h4,  32'hBAD0_0000, 1};
    tbl[12] = '{1, 0, TOP,          32'h0,         1};
    tbl[13] = '{1, 0, BASE - 32'h4, 32'h0,         1};
    tbl[14] = '{1, 0, BASE,         32'h0,         1};

    err_m = 1'b0;
    cnt_m = '0;
    @(posedge CLK);
    #1;
    mon_en = 1'b1;
    do_reset(2);

    step(1, 1, BASE + 32'h4, 32'h1234_5678);
    step(1, 0, BASE + 32'h4, 32'h0);
    step(0, 0, 32'h0, 32'h0);
    chk_status(1'b0, 16'd2);

    step(1, 1, BASE,         32'hA);
    step(1, 1, BASE + 32'h4, 32'hB);
    step(1, 1, BASE + 32'h8, 32'hC);
    step(1, 0, BASE,         32'h0);
    step(1, 0, BASE + 32'h4, 32'h0);
    step(1, 0, BASE + 32'h8, 32'h0);
    repeat (4) step(0, 0, 32'h0, 32'h0);

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].cs, tbl[i].we, tbl[i].a, tbl[i].wd);
      for (int k = 0; k < 3; k++)
        check(err[k] === tbl[i].err, $sformatf("vec%0d_err", i),
              32'(err[k]), 32'(tbl[i].err));
    end
    repeat (4) step(0, 0, 32'h0, 32'h0);
    chk_status(err_m, cnt_m);

    step(1, 0, BASE + 32'h4, 32'h0);
    do_reset(1);
    step(1, 0, BASE + 32'h4, 32'h0);
    repeat (4) step(0, 0, 32'h0, 32'h0);

    repeat (65540) step(1, 0, BASE + 32'h4, 32'h0);
    repeat (4) step(0, 0, 32'h0, 32'h0);
    chk_status(1'b0, 16'hFFFF);

    for (int k = 0; k < 3; k++)
      check(sbq[k].size() == 0, "sb_drained",
            32'(sbq[k].size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder on the CPU data bus: the target end of the CS/WE/ADDR/Data_BUS_WRITE/Data_BUS_READ interface that the cpu core drives as initiator.
- Decodes a word-aligned address window and services writes in one cycle.
- Returns reads through a fixed-latency pipeline.
- Flags illegal accesses and counts bus transactions for debug.
- Sits beside the program memory in the system top and connects directly to the cpu data-bus ports.

Parameters:
- ADDR_WIDTH, 10, log2 of memory depth in 32-bit words (DEPTH = 2**ADDR_WIDTH).
- BASE_ADDR, 32'h0000_2000, byte address of word 0; must be 4-byte aligned.
- RD_LATENCY, 1, cycles from read issue to data valid; legal range 1..3.
- ERR_DATA, 32'hDEAD_BEEF, value returned for reads that fail decode.

Ports:
- CLK, input, 1, system clock; all logic on its rising edge.
- reset, input, 1, synchronous active-high reset.
- CS, input, 1, chip select; a transaction occurs in every cycle where CS=1.
- WE, input, 1, 1=write, 0=read; qualified by CS.
- ADDR, input, 32, byte address.
- Data_BUS_WRITE, input, 32, write data.
- Data_BUS_READ, output, 32, read data; holds its value until the next read completes.
- rd_valid, output, 1, one-cycle pulse when Data_BUS_READ updates.
- addr_err, output, 1, sticky flag for an out-of-range or misaligned access.
- access_cnt, output, 16, saturating count of accepted transactions.
- busy, output, 1, scrub in progress; see Optional Feature.

Behaviour:
- Decode: hit = (ADDR[1:0]==0) && (BASE_ADDR <= ADDR <= BASE_ADDR + 4*DEPTH - 4). Word index = (ADDR - BASE_ADDR) >> 2, truncated to ADDR_WIDTH bits.
- Write: CS=1, WE=1, hit=1 → mem[index] <= Data_BUS_WRITE at that edge. No response pulse.
- Read: CS=1, WE=0 → the array is sampled at the issue edge. The value, or ERR_DATA on a miss, enters a RD_LATENCY-deep shift pipeline with a valid bit.
  - Data_BUS_READ and rd_valid update exactly RD_LATENCY edges after issue.
  - Back-to-back reads, one per cycle, are fully pipelined; results return in issue order.
- Read issued in cycle N to an address written in cycle N+1 returns the old value. A write in cycle N followed by a read in N+1 returns the new value.
- Miss on a write: the array is unchanged and addr_err is set.
- Miss on a read: returns ERR_DATA with rd_valid=1 and sets addr_err.
- addr_err clears only on reset.
- access_cnt increments on every CS=1 cycle, hit or miss, accepted while busy=0. It saturates at 16'hFFFF.
- CS=0: no array or counter activity. The pipeline keeps draining.
- Reset values: Data_BUS_READ=0, rd_valid=0, addr_err=0, access_cnt=0, all pipeline valid bits=0.
  - Array contents are not affected, except as described under the macro.
  - Reset asserted while reads are in flight discards them; no rd_valid pulse is produced for them after reset.
- WE with CS=0 is ignored.

Optional Feature:
- Macro: DMEM_SCRUB_EN.
- Defined: a two-state FSM, IDLE/SCRUB.
  - Reset forces SCRUB with the scrub pointer at 0 and busy=1.
  - Each cycle in SCRUB writes mem[ptr] <= 0 and then increments ptr.
  - After writing DEPTH-1, the FSM moves to IDLE the next edge and busy drops to 0. Total busy time is DEPTH cycles after reset deasserts.
  - While busy=1, bus transactions are ignored: no write, no rd_valid, no counter increment, no addr_err.
  - Reset asserted mid-scrub restarts the scrub at ptr 0.
- Undefined: no FSM, busy tied to 0, and the array powers up uninitialised (X in simulation).

Test Plan:
- Write/read at latency 1, RD_LATENCY=1: write 32'h1234_5678 to 32'h2004, then read 32'h2004 next cycle → Data_BUS_READ=32'h1234_5678 with a single rd_valid pulse one edge after issue; access_cnt=2.
- Pipelined reads, RD_LATENCY=3: pre-write 32'hA, 32'hB, 32'hC to 32'h2000/2004/2008, then issue three back-to-back reads → rd_valid high for 3 consecutive cycles starting 3 edges after the first issue, with data A, B, C in order.
- Misses:
  - Read 32'h2002 (misaligned) → ERR_DATA 32'hDEAD_BEEF and addr_err=1.
  - Write 32'h3000 (out of range, DEPTH=1024) → memory unchanged and addr_err stays 1 until reset.
- Reset in flight: with RD_LATENCY=2, issue a read, then assert reset the next cycle → no rd_valid pulse; all outputs 0; a previously written word is still readable after reset when the macro is undefined.
- Counter saturation: hold CS=1, WE=0 for 65 540 cycles → access_cnt stops at 16'hFFFF.
- Scrub (DMEM_SCRUB_EN, ADDR_WIDTH=4): release reset → busy=1 for exactly 16 cycles; a write to 32'h2000 during busy is dropped; afterwards a read of 32'h2000 returns 0 and access_cnt counts only post-busy accesses.
